serial_word_shifter: RTL
========================

Name: serial_word_shifter

Overview:
Parallel-to-serial front end that feeds the serial pattern recogniser. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per bit_en tick. A one-entry holding register lets back-to-back words stream with no idle gap. Between words the line is held at IDLE_BIT, so idle periods never create spurious pattern matches downstream.

Parameters:
WIDTH, 8, word width in bits (>=2)
LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB shifted first
IDLE_BIT, 1, value driven on ser_out when no word is being shifted

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_data  input  WIDTH  parallel word
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word; equals !hold_full (combinational)
bit_en  input  1  bit-rate tick; shifting advances only on cycles with bit_en=1
ser_out  output  1  serial bit to the recogniser (registered)
ser_valid  output  1  high while ser_out carries a data bit (registered)
frame_done  output  1  one-cycle pulse after the last bit of a word when no next word is pending
busy  output  1  state==SHIFT or hold_full

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, hold_full=0, bit_cnt=0.
  - ser_out=IDLE_BIT, ser_valid=0, frame_done=0.
  - in_ready=1, busy=0.
  - Reset mid-word discards the shift and hold contents; no partial word resumes.
- Accept: on a cycle with in_valid && in_ready, hold <= in_data and hold_full <= 1. in_valid without in_ready has no effect.
- Source rule: the source holds in_data stable until accepted.
- States: IDLE, SHIFT. Registers: shreg[WIDTH], bit_cnt (remaining bits, clog2(WIDTH+1) wide), hold[WIDTH], hold_full.
- On a cycle with bit_en=1:
  - bit_cnt>0: ser_out <= next bit of shreg (MSB or LSB per LSB_FIRST); shreg shifts; bit_cnt--; ser_valid <= 1; stay in SHIFT.
  - bit_cnt==0 and hold_full: load shreg from hold; hold_full <= 0; ser_out <= first bit; bit_cnt <= WIDTH-1; ser_valid <= 1; state <= SHIFT.
  - bit_cnt==0 and !hold_full: ser_out <= IDLE_BIT; ser_valid <= 0; state <= IDLE. frame_done pulses for one clk only if the previous state was SHIFT.
- On a cycle with bit_en=0: all shift state holds; ser_out/ser_valid keep their values (each bit lasts a full bit period); frame_done=0.
- Simultaneous events:
  - Accept and hold-to-shreg load cannot collide: accept requires !hold_full, load requires hold_full.
  - A word accepted in cycle t can be loaded on a bit_en at t+1 or later, never at t.
- Latency: a word accepted at t with bit_en=1 every cycle gives its first bit on ser_out at t+2. WIDTH bits follow back to back.
- Back-to-back: if hold refills before bit_cnt reaches 0, the next word's first bit follows the previous last bit on the very next bit_en. No IDLE bit is inserted and frame_done does not pulse.
- in_ready drops the cycle after acceptance and rises the cycle after the hold-to-shreg load.

Decomposition:
- Shared package pattern_pkg holds:
  - the state enum/encodings (SH_IDLE=1'b0, SH_SHIFT=1'b1)
  - the default WIDTH constant
  - the IDLE_BIT default, shared with the recogniser testbench
- Single module; no sub-module needed. The holding register is too small to split out.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with no clk edge -> ser_out=1, ser_valid=0, in_ready=1, busy=0 immediately.
2. Single word, bit_en=1 always, WIDTH=8, in_data=8'b0011_0111 at t=0 -> ser_out shows 0,0,1,1,0,1,1,1 at t=2..9 with ser_valid=1; frame_done=1 at t=10 with ser_out=1, ser_valid=0.
3. Back-to-back: words 8'hA5 then 8'h3C, the second offered while the first shifts -> 16 contiguous valid bits 10100101_00111100, no idle bit, one frame_done after the last.
4. Paced: bit_en every 4th clk -> each bit held exactly 4 clks. in_ready stays 0 while hold is full and in_valid is held high, then the second word is accepted exactly one cycle after its load.
5. Async reset after 3 bits of 8'hFF -> outputs go to their reset values at once; after release a new word 8'h0F shifts all 8 bits correctly from its first bit.
6. LSB_FIRST=1, in_data=8'b0000_0110 -> ser_out sequence 0,1,1,0,0,0,0,0. Feeding it to the recogniser yields found=1 once.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the serial front end and the pattern recogniser:
// shifter state encoding and default word/idle-line settings.
package pattern_pkg;

    typedef enum logic {
        SH_IDLE  = 1'b0,
        SH_SHIFT = 1'b1
    } sh_state_e;

    localparam int   DEF_WIDTH    = 8;
    localparam logic DEF_IDLE_BIT = 1'b1;

endpackage

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial shifter with a one-word holding register so back-to-back
// words stream gap-free; the line rests at IDLE_BIT between words.
module serial_word_shifter
    import pattern_pkg::*;
#(
    parameter int   WIDTH     = DEF_WIDTH,
    parameter bit   LSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    sh_state_e        r_state, w_state_nx;
    logic [WIDTH-1:0] r_shreg, w_shreg_nx;
    logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nx;
    logic [WIDTH-1:0] r_hold, w_hold_nx;
    logic             r_hold_full, w_hold_full_nx;
    logic             r_ser_out, w_ser_out_nx;
    logic             r_ser_valid, w_ser_valid_nx;
    logic             r_frame_done, w_frame_done_nx;

    // First bit out of a word and what remains after it is consumed.
    logic             w_hold_first, w_shreg_first;
    logic [WIDTH-1:0] w_hold_rest, w_shreg_rest;

    assign w_hold_first  = LSB_FIRST ? r_hold[0]  : r_hold[WIDTH-1];
    assign w_shreg_first = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
    assign w_hold_rest   = LSB_FIRST ? (r_hold >> 1)  : (r_hold << 1);
    assign w_shreg_rest  = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SH_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_ser_out    <= IDLE_BIT;
            r_ser_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_shreg      <= w_shreg_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_hold       <= w_hold_nx;
            r_hold_full  <= w_hold_full_nx;
            r_ser_out    <= w_ser_out_nx;
            r_ser_valid  <= w_ser_valid_nx;
            r_frame_done <= w_frame_done_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_shreg_nx      = r_shreg;
        w_bit_cnt_nx    = r_bit_cnt;
        w_hold_nx       = r_hold;
        w_hold_full_nx  = r_hold_full;
        w_ser_out_nx    = r_ser_out;
        w_ser_valid_nx  = r_ser_valid;
        w_frame_done_nx = 1'b0;

        // Accept only into an empty hold, so it never collides with a load below.
        if (in_valid && !r_hold_full) begin
            w_hold_nx      = in_data;
            w_hold_full_nx = 1'b1;
        end

        if (bit_en) begin
            if (r_bit_cnt != '0) begin
                w_ser_out_nx   = w_shreg_first;
                w_shreg_nx     = w_shreg_rest;
                w_bit_cnt_nx   = r_bit_cnt - CW'(1);
                w_ser_valid_nx = 1'b1;
                w_state_nx     = SH_SHIFT;
            end else if (r_hold_full) begin
                // The first bit goes straight to the line; shreg keeps the rest.
                w_ser_out_nx   = w_hold_first;
                w_shreg_nx     = w_hold_rest;
                w_bit_cnt_nx   = CW'(WIDTH - 1);
                w_ser_valid_nx = 1'b1;
                w_hold_full_nx = 1'b0;
                w_state_nx     = SH_SHIFT;
            end else begin
                w_ser_out_nx    = IDLE_BIT;
                w_ser_valid_nx  = 1'b0;
                w_state_nx      = SH_IDLE;
                w_frame_done_nx = (r_state == SH_SHIFT);
            end
        end
    end

    assign in_ready   = !r_hold_full;
    assign busy       = (r_state == SH_SHIFT) || r_hold_full;
    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign frame_done = r_frame_done;

endmodule
